// File: rtl/bitonic_pkg.sv
// Shared types, constants and helper functions for the bitonic sort frame controller.
package bitonic_pkg;

  localparam int FIFO_DEPTH = 2;

  typedef enum logic {
    ST_FILL   = 1'b0,
    ST_LAUNCH = 1'b1
  } fill_state_t;

  // Pad value that always sorts behind every real element for the given ordering.
  function automatic logic [63:0] pad_value(input int dw, input bit polarity, input bit is_signed);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < dw) v[i] = ~polarity;
    end
    if (is_signed) v[dw-1] = ~v[dw-1];
    return v;
  endfunction

  function automatic int default_latency(input int order, input bit pipe_reg);
    return pipe_reg ? ((order + 1) * (order + 2)) / 2 : 1;
  endfunction

endpackage

// File: rtl/bitonic_sort_ctrl_fifo.sv
// Two-entry frame buffer holding {count, sorted vector} pairs between network and serializer.
module bitonic_frame_fifo
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 8,
  parameter int CW         = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_push,
  input  logic [CW-1:0]           i_push_cnt,
  input  logic [N*DATA_WIDTH-1:0] i_push_vec,
  input  logic                    i_pop,
  output logic [1:0]              o_occ,
  output logic [CW-1:0]           o_head_cnt,
  output logic [N*DATA_WIDTH-1:0] o_head_vec
);

  logic [CW-1:0]           r_cnt_mem [FIFO_DEPTH];
  logic [N*DATA_WIDTH-1:0] r_vec_mem [FIFO_DEPTH];
  logic                    r_wptr;
  logic                    r_rptr;
  logic [1:0]              r_occ;
  logic                    w_push_ok;
  logic                    w_pop_ok;

  assign w_pop_ok  = i_pop && (r_occ != 2'd0);
  assign w_push_ok = i_push && ((r_occ != 2'(FIFO_DEPTH)) || w_pop_ok);

  // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_cnt_mem[r_wptr] <= i_push_cnt;
      r_vec_mem[r_wptr] <= i_push_vec;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_occ  <= 2'd0;
    end else begin
      if (w_push_ok) r_wptr <= ~r_wptr;
      if (w_pop_ok)  r_rptr <= ~r_rptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_occ      = r_occ;
  assign o_head_cnt = r_cnt_mem[r_rptr];
  assign o_head_vec = r_vec_mem[r_rptr];

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Frame controller around a pipelined bitonic sorting network.
// Optional statistics counters are enabled with `define BITONIC_SORT_CTRL_STATS_EN.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ORDER      = 2,
  parameter int POLARITY   = 0,
  parameter int SIGNED     = 0,
  parameter int LATENCY    = default_latency(ORDER, 1'b1)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [DATA_WIDTH-1:0]                s_data,
  input  logic                                 s_last,
  output logic [DATA_WIDTH*(2**(ORDER+1))-1:0] sort_data_o,
  input  logic [DATA_WIDTH*(2**(ORDER+1))-1:0] sort_data_i,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [DATA_WIDTH-1:0]                m_data,
  output logic                                 m_last
`ifdef BITONIC_SORT_CTRL_STATS_EN
  ,
  output logic [31:0]                          stat_frames,
  output logic [31:0]                          stat_stall
`endif
);

  localparam int N  = 2 ** (ORDER + 1);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  localparam logic [DATA_WIDTH-1:0] PAD =
    DATA_WIDTH'(pad_value(DATA_WIDTH, POLARITY != 0, SIGNED != 0));

  fill_state_t                      r_state;
  fill_state_t                      w_state_nxt;
  logic                             r_rdy_en;
  logic [IW-1:0]                    r_widx;
  logic [CW-1:0]                    r_cnt;
  logic [N-1:0][DATA_WIDTH-1:0]     r_fill;
  logic                             w_accept;
  logic                             w_last_beat;
  logic                             w_launch;
  logic                             w_credit;
  int                               w_inflight;
  logic [LATENCY-1:0]               r_vld;
  logic [CW-1:0]                    r_tag_cnt [LATENCY];
  logic                             w_push;
  logic                             w_pop;
  logic [1:0]                       w_occ;
  logic [CW-1:0]                    w_head_cnt;
  logic [N-1:0][DATA_WIDTH-1:0]     w_head_vec;
  logic [IW-1:0]                    r_ridx;

  // s_ready is held low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  assign s_ready     = r_rdy_en && (r_state == ST_FILL);
  assign w_accept    = s_valid && s_ready;
  assign w_last_beat = s_last || (r_widx == IW'(N - 1));
  assign sort_data_o = r_fill;

  // Credit counts registered state only, so a same-cycle pop never frees a slot early.
  always_comb begin
    w_inflight = 0;
    for (int i = 0; i < LATENCY; i++) begin
      if (r_vld[i]) w_inflight++;
    end
    w_credit = (w_inflight + int'(w_occ)) < FIFO_DEPTH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_accept && w_last_beat) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        if (w_credit) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
      r_widx <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_accept) begin
        r_fill[r_widx] <= s_data;
        if (w_last_beat) begin
          r_cnt <= CW'(r_widx) + CW'(1);
          for (int i = 0; i < N; i++) begin
            if (i > int'(r_widx)) r_fill[i] <= PAD;
          end
        end else begin
          r_widx <= r_widx + IW'(1);
        end
      end
      if (w_launch) r_widx <= '0;
    end
  end

  // Tag pipeline mirroring the network latency; the tail marks a sorted vector at sort_data_i.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_tag_cnt[i] <= '0;
    end else begin
      r_vld[0]     <= w_launch;
      r_tag_cnt[0] <= r_cnt;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i]     <= r_vld[i-1];
        r_tag_cnt[i] <= r_tag_cnt[i-1];
      end
    end
  end

  assign w_push = r_vld[LATENCY-1];

  bitonic_frame_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .N          (N),
    .CW         (CW)
  ) u_frame_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_cnt (r_tag_cnt[LATENCY-1]),
    .i_push_vec (sort_data_i),
    .i_pop      (w_pop),
    .o_occ      (w_occ),
    .o_head_cnt (w_head_cnt),
    .o_head_vec (w_head_vec)
  );

  assign m_valid = (w_occ != 2'd0);
  assign m_data  = m_valid ? w_head_vec[r_ridx] : '0;
  assign m_last  = m_valid && ((CW'(r_ridx) + CW'(1)) == w_head_cnt);
  assign w_pop   = m_valid && m_ready && m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ridx <= '0;
    end else if (m_valid && m_ready) begin
      r_ridx <= m_last ? '0 : r_ridx + IW'(1);
    end
  end

`ifdef BITONIC_SORT_CTRL_STATS_EN
  logic [31:0] r_stat_frames;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_frames <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_pop && (r_stat_frames != '1)) r_stat_frames <= r_stat_frames + 32'd1;
      if ((r_state == ST_LAUNCH) && !w_credit && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_frames = r_stat_frames;
  assign stat_stall  = r_stat_stall;
`endif

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Directed self-checking bench: ascending unsigned DUT plus a descending signed DUT.
module tb_bitonic_sort_ctrl;

  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int LAT = 6;
  localparam int VW  = DW * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          s_valid, s_last, sel;
  logic [DW-1:0] s_data;
  logic          m_ready_fix, rnd_mode, r_rnd;

  logic          s_valid_a, s_ready_a, m_valid_a, m_ready_a, m_last_a;
  logic [DW-1:0] m_data_a;
  logic [VW-1:0] sort_data_o_a, sort_data_i_a;
  logic          s_valid_b, s_ready_b, m_valid_b, m_ready_b, m_last_b;
  logic [DW-1:0] m_data_b;
  logic [VW-1:0] sort_data_o_b, sort_data_i_b;
  logic          s_ready_sel;

  assign s_valid_a   = s_valid && !sel;
  assign s_valid_b   = s_valid && sel;
  assign s_ready_sel = sel ? s_ready_b : s_ready_a;
  assign m_ready_a   = rnd_mode ? r_rnd : m_ready_fix;
  assign m_ready_b   = 1'b1;

`ifdef BITONIC_SORT_CTRL_STATS_EN
  logic [31:0] stat_frames_a, stat_stall_a, stat_frames_b, stat_stall_b;
`endif

  bitonic_sort_ctrl #(.DATA_WIDTH(DW), .ORDER(2), .POLARITY(0), .SIGNED(0), .LATENCY(LAT)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data), .s_last(s_last),
    .sort_data_o(sort_data_o_a), .sort_data_i(sort_data_i_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a), .m_last(m_last_a)
`ifdef BITONIC_SORT_CTRL_STATS_EN
    , .stat_frames(stat_frames_a), .stat_stall(stat_stall_a)
`endif
  );

  bitonic_sort_ctrl #(.DATA_WIDTH(DW), .ORDER(2), .POLARITY(1), .SIGNED(1), .LATENCY(LAT)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data), .s_last(s_last),
    .sort_data_o(sort_data_o_b), .sort_data_i(sort_data_i_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b), .m_last(m_last_b)
`ifdef BITONIC_SORT_CTRL_STATS_EN
    , .stat_frames(stat_frames_b), .stat_stall(stat_stall_b)
`endif
  );

  function automatic bit elem_gt(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn);
    return sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  // Behavioural sorting network: full sort of all N lanes, pads included.
  function automatic logic [VW-1:0] net_sort(input logic [VW-1:0] v, input bit desc, input bit sgn);
    logic [DW-1:0] e [N];
    logic [DW-1:0] t;
    logic [VW-1:0] r;
    bit            sw;
    for (int i = 0; i < N; i++) e[i] = v[DW*i +: DW];
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        sw = desc ? elem_gt(e[j+1], e[j], sgn) : elem_gt(e[j], e[j+1], sgn);
        if (sw) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
      end
    end
    for (int i = 0; i < N; i++) r[DW*i +: DW] = e[i];
    return r;
  endfunction

  logic [VW-1:0] net_a [LAT];
  logic [VW-1:0] net_b [LAT];
  always @(posedge clk) begin
    net_a[0] <= net_sort(sort_data_o_a, 1'b0, 1'b0);
    net_b[0] <= net_sort(sort_data_o_b, 1'b1, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      net_a[i] <= net_a[i-1];
      net_b[i] <= net_b[i-1];
    end
  end
  assign sort_data_i_a = net_a[LAT-1];
  assign sort_data_i_b = net_b[LAT-1];

  always begin
    @(posedge clk);
    #2;
    r_rnd = 1'($urandom_range(0, 1));
  end

  int            checks = 0;
  int            errors = 0;
  int            stab_err = 0;
  int            occ_err = 0;
  int            mv_count = 0;
  logic [DW:0]   got_a [$];
  logic [DW:0]   got_b [$];
  logic [DW:0]   exp_a [$];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  // Output monitor: records handshakes and checks stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!m_valid_a || m_data_a !== prev_data || m_last_a !== prev_last))
        stab_err++;
      if (m_valid_a && m_ready_a) got_a.push_back({m_last_a, m_data_a});
      if (m_valid_b && m_ready_b) got_b.push_back({m_last_b, m_data_b});
      if (m_valid_a) mv_count++;
      if (dut_a.w_occ > 2'd2) occ_err++;
      prev_stall = m_valid_a && !m_ready_a;
      prev_data  = m_data_a;
      prev_last  = m_last_a;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DW-1:0] v [N], input int n);
    bit ok;
    bit all_ok;
    int t;
    all_ok = 1'b1;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      t  = 0;
      s_valid = 1'b1;
      s_data  = v[i];
      s_last  = (i == n - 1);
      while (!ok && t < 400) begin
        @(negedge clk);
        if (s_ready_sel) ok = 1'b1;
        t++;
        @(posedge clk);
        #1;
      end
      if (!ok) all_ok = 1'b0;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    check("send_accept", all_ok, 1'b1);
  endtask

  task automatic wait_got(input bit use_b, input int n, input int budget);
    int t;
    t = 0;
    while (((use_b ? got_b.size() : got_a.size()) < n) && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("wait_output", (use_b ? got_b.size() : got_a.size()) >= n, 1'b1);
    tick(1);
  endtask

  // Reference: the real elements of a frame in ascending unsigned order, last flag on the final one.
  task automatic expect_frame(input logic [DW-1:0] v [N], input int n);
    logic [DW-1:0] a [N];
    logic [DW-1:0] t;
    for (int i = 0; i < n; i++) a[i] = v[i];
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    end
    for (int i = 0; i < n; i++) exp_a.push_back({(i == n - 1), a[i]});
  endtask

  task automatic compare_exp(input string tag, input int count);
    logic [DW:0] g;
    logic [DW:0] e;
    for (int i = 0; i < count; i++) begin
      if (got_a.size() == 0 || exp_a.size() == 0) break;
      g = got_a.pop_front();
      e = exp_a.pop_front();
      check(tag, g, e);
    end
  endtask

  initial begin
    logic [DW-1:0] vv [N];
    logic [DW-1:0] e1 [N];
    logic [DW:0]   g;
    logic [VW-1:0] exp_pad;
    int            n, total;

    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; sel = 1'b0;
    m_ready_fix = 1'b1; rnd_mode = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_s_ready", s_ready_a, 1'b0);
    check("rst_m_valid", m_valid_a, 1'b0);
    check("rst_m_last", m_last_a, 1'b0);
    check("rst_m_data", m_data_a, '0);
    check("rst_sort_data_o", sort_data_o_a, '0);
    tick(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_first_cycle", s_ready_a, 1'b0);
    tick(1);
    @(negedge clk);
    check("s_ready_rises", s_ready_a, 1'b1);
    tick(1);

    // Full frame with latency measurement.
    vv = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
    e1 = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
    send_frame(vv, 8);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid_a && n < 40);
    check("first_mvalid_latency", n, 8);
    tick(1);
    wait_got(1'b0, 8, 100);
    for (int i = 0; i < 8; i++) begin
      g = (got_a.size() > 0) ? got_a.pop_front() : '0;
      check("full_data", g[DW-1:0], e1[i]);
      check("full_last", g[DW], (i == 7));
    end

    // Short frame: padding in the fill register, only real elements emitted.
    vv = '{16'd5, 16'hFFFF, 16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(vv, 3);
    @(negedge clk);
    exp_pad = {{5{16'hFFFF}}, 16'h0002, 16'hFFFF, 16'h0005};
    check("short_padded_vector", sort_data_o_a, exp_pad);
    check("short_s_ready_launch", s_ready_a, 1'b0);
    tick(1);
    wait_got(1'b0, 3, 100);
    e1 = '{16'd2, 16'd5, 16'hFFFF, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 3; i++) begin
      g = (got_a.size() > 0) ? got_a.pop_front() : '0;
      check("short_data", g[DW-1:0], e1[i]);
      check("short_last", g[DW], (i == 2));
    end
    tick(20);
    check("short_no_pad_emitted", got_a.size(), 0);

    // Signed descending on the second instance.
    sel = 1'b1;
    vv = '{16'hFFFD, 16'd4, 16'hFFF8, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    send_frame(vv, 4);
    sel = 1'b0;
    wait_got(1'b1, 4, 100);
    e1 = '{16'd4, 16'd0, 16'hFFFD, 16'hFFF8, 16'd0, 16'd0, 16'd0, 16'd0};
    for (int i = 0; i < 4; i++) begin
      g = (got_b.size() > 0) ? got_b.pop_front() : '0;
      check("sdesc_data", g[DW-1:0], e1[i]);
      check("sdesc_last", g[DW], (i == 3));
    end

    // Backpressure: two frames buffered, third waits for credit.
    m_ready_fix = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < N; i++) vv[i] = 16'((k + 1) * 1000 + ((i * 5) % 8) * 7);
      expect_frame(vv, 8);
      send_frame(vv, 8);
    end
    tick(20);
    @(negedge clk);
    check("bp_s_ready_low", s_ready_a, 1'b0);
    check("bp_m_valid", m_valid_a, 1'b1);
    check("bp_occ_two", dut_a.w_occ, 2'd2);
    check("bp_nothing_inflight", dut_a.r_vld, '0);
    check("bp_no_output", got_a.size(), 0);
    check("bp_head_data", m_data_a, exp_a[0][DW-1:0]);
`ifdef BITONIC_SORT_CTRL_STATS_EN
    check("bp_stat_stall", stat_stall_a > 32'd0, 1'b1);
`endif
    tick(1);
    m_ready_fix = 1'b1;
    for (int i = 0; i < N; i++) vv[i] = 16'(4000 + ((i * 3) % 8) * 11);
    expect_frame(vv, 8);
    send_frame(vv, 8);
    wait_got(1'b0, 32, 400);
    compare_exp("bp_order", 32);
`ifdef BITONIC_SORT_CTRL_STATS_EN
    check("stat_frames", stat_frames_a, 32'd6);
`endif

    // Reset three cycles after launch discards the frame.
    vv = '{16'd50, 16'd40, 16'd30, 16'd20, 16'd10, 16'd60, 16'd70, 16'd80};
    send_frame(vv, 8);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    mv_count = 0;
    tick(15);
    check("rst_mid_no_mvalid", mv_count, 0);
    check("rst_mid_no_output", got_a.size(), 0);
    vv = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
    expect_frame(vv, 8);
    send_frame(vv, 8);
    wait_got(1'b0, 8, 100);
    compare_exp("post_rst_frame", 8);

    // Random frames under random backpressure.
    rnd_mode = 1'b1;
    total = 0;
    for (int f = 0; f < 200; f++) begin
      n = $urandom_range(1, N);
      for (int i = 0; i < N; i++) vv[i] = 16'($urandom);
      expect_frame(vv, n);
      total += n;
      send_frame(vv, n);
    end
    wait_got(1'b0, total, 5000);
    rnd_mode = 1'b0;
    compare_exp("random_frames", total);

    check("m_data_stable_stalled", stab_err, 0);
    check("occ_bound", occ_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
